sipo_loader: RTL and testbench
==============================

# sipo_loader

Serial-in, parallel-out matrix loader: accepts a stream of 32-bit words over a valid/ready handshake and writes them in row-major order into a registered N×M word array presented in parallel. It is the write-side counterpart of the TPU's parallel-in/serial-out result reader. It fills operand/weight matrices one word per cycle from the host-side serial link before the array computes.

## Interface
- M, 256, number of columns per row (inner index).
- N, 256, number of rows (outer index).
- IW, 8, index width; must satisfy 2^IW ≥ max(N, M).

- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new load; restarts the write position at (0,0).
- in_valid  input  1  in_data holds a valid word.
- in_data  input  32  serial input word.
- in_ready  output  1  loader accepts a word this cycle.
- data_out  output  32 × [N-1:0][M-1:0]  parallel matrix, indexed [row][col].
- wr_n  output  IW  row index of the next word to be written.
- wr_m  output  IW  column index of the next word to be written.
- busy  output  1  high in LOAD state.
- full  output  1  high in FULL state (all N·M words written).
- done  output  1  one-cycle pulse when the final word of a load is written.

## Operation
- States: IDLE, LOAD, FULL.
- IDLE: in_ready=0. start → LOAD; wr_n=wr_m=0.
- LOAD: busy=1. in_ready = ~start (combinational). Beat accepted when in_valid & in_ready.
  - On accept: data_out[wr_n][wr_m] ← in_data. If wr_m==M-1: wr_m←0, wr_n←wr_n+1; else wr_m←wr_m+1.
  - Accept at (N-1, M-1): → FULL, wr_n=wr_m=0, done=1 for exactly one cycle.
  - in_valid low: no change; stall indefinitely, no timeout.
  - start in LOAD: beat in that cycle is not accepted (in_ready=0). Counters restart at (0,0), state stays LOAD. Already-written words are retained.
- FULL: full=1, in_ready=0, in_valid ignored. start → LOAD from (0,0). data_out holds until overwritten word by word.
- Only words at accepted positions change; data_out is never cleared except by rst.
- Reset (any state, mid-load included), taking effect on the next edge: state=IDLE; data_out all zeros; wr_n=wr_m=0; done=0; full=0; busy=0; in_ready=0. A partial load is abandoned.
- Degenerate sizes: N=1 or M=1 is legal. With N=M=1, a single accepted beat goes LOAD→FULL and pulses done.

## Timing
- Handshake: transfer on a rising edge where in_valid & in_ready are both high. in_ready depends only on state and start, never on in_valid.
- Write latency 1: a word accepted at edge k is visible on data_out after edge k. wr_n/wr_m advance at the same edge.
- done and full assert after the edge that accepts the final word, together with that word appearing on data_out. done drops after one cycle; full stays high until start or rst.
- Throughput: one word per cycle. A full load with in_valid held high takes N·M cycles from the first LOAD cycle.
- start→LOAD: first beat can be accepted the cycle after start is sampled.
- rst has priority over start and the handshake.

## Test plan
- Reset check, N=2 M=3: assert rst with start/in_valid high → all data_out 0, in_ready=0, busy=0, full=0, done=0, wr_n=wr_m=0.
- Full load, N=2 M=3: start, then in_valid held high with words 1..6 → data_out[0]=1,2,3 and data_out[1]=4,5,6. done pulses once, on the cycle after word 6 is accepted. full stays high; in_ready=0.
- Backpressure/stall: toggle in_valid pseudo-randomly while loading 0xA0..0xA5 → same placement; wr_m/wr_n advance only on accepted beats; busy high throughout.
- Row wrap, M=3: after the third accepted beat → wr_m=0, wr_n=1.
- Restart mid-load: after 4 beats, assert start with in_valid high and in_data=0xDEAD → that beat is not accepted (in_ready=0). Next beat 0xBEEF lands at [0][0]; [1][0] keeps its earlier value.
- FULL and reset behaviour: in FULL, drive in_valid with 0x55 → data_out unchanged. Assert rst mid-load → IDLE, data_out zeroed; next start loads from (0,0).

Source files
------------

// File: rtl/sipo_loader.sv
// sipo_loader: serial-in, parallel-out matrix loader.
//
// Accepts 32-bit words over a valid/ready handshake and writes them in
// row-major order into a registered N x M word array that is presented in
// parallel. It is the write-side counterpart of the parallel-in/serial-out
// result reader.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-high reset
//   start     begin a new load; write position returns to (0,0)
//   in_valid  in_data holds a valid word
//   in_data   serial input word (32 bits)
//   in_ready  a word is accepted this cycle if in_valid is also high
//   data_out  parallel matrix [row][col] of 32-bit words
//   wr_n      row index of the next word to be written
//   wr_m      column index of the next word to be written
//   busy      high while loading
//   full      high once all N*M words of a load are written
//   done      one-cycle pulse after the final word of a load is written

// One matrix row: a bank of M word registers, written one column at a time.
module sipo_row #(
    parameter int M  = 256,
    parameter int IW = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IW-1:0]         col,
    input  logic [31:0]           din,
    output logic [M-1:0][31:0]    q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            for (int c = 0; c < M; c++) begin
                if (we && col == IW'(c)) q[c] <= din;
            end
        end
    end

endmodule

module sipo_loader #(
    parameter int M  = 256,
    parameter int N  = 256,
    parameter int IW = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic [31:0]                 in_data,
    output logic                        in_ready,
    output logic [N-1:0][M-1:0][31:0]   data_out,
    output logic [IW-1:0]               wr_n,
    output logic [IW-1:0]               wr_m,
    output logic                        busy,
    output logic                        full,
    output logic                        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic accept;
    logic last_pos;
    logic last_col;

    // A start in LOAD takes priority over the beat in the same cycle, so
    // ready is withheld combinationally rather than letting the beat land
    // at the old position.
    assign in_ready = (state_q == LOAD) && !start;
    assign accept   = in_ready && in_valid;
    assign last_col = (wr_m == IW'(M-1));
    assign last_pos = last_col && (wr_n == IW'(N-1));

    assign busy = (state_q == LOAD);
    assign full = (state_q == FULL);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: if (!start && accept && last_pos) state_d = FULL;
            FULL: if (start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    // Write position and the completion pulse. Any start re-arms the load
    // at (0,0); the final accepted beat also wraps the position to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_n <= '0;
            wr_m <= '0;
            done <= 1'b0;
        end else begin
            done <= accept && last_pos;
            if (start || (accept && last_pos)) begin
                wr_n <= '0;
                wr_m <= '0;
            end else if (accept) begin
                if (last_col) begin
                    wr_m <= '0;
                    wr_n <= wr_n + 1'b1;
                end else begin
                    wr_m <= wr_m + 1'b1;
                end
            end
        end
    end

    // Each row only sees a write enable when the current row index selects it.
    for (genvar r = 0; r < N; r++) begin : g_row
        sipo_row #(.M(M), .IW(IW)) u_row (
            .clk (clk),
            .rst (rst),
            .we  (accept && (wr_n == IW'(r))),
            .col (wr_m),
            .din (in_data),
            .q   (data_out[r])
        );
    end

endmodule

// File: tb/tb_sipo_loader.sv
// Testbench for sipo_loader (N=2, M=3). A linear-address model holds the
// expected matrix contents, write position and mode; a negedge process
// compares every output against it each cycle, and directed steps add
// hand-computed literal checks.
module tb_sipo_loader;

    localparam int N  = 2;
    localparam int M  = 3;
    localparam int IW = 8;
    localparam int W  = N*M*32;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       in_valid;
    logic [31:0]                in_data;
    logic                       in_ready;
    logic [N-1:0][M-1:0][31:0]  data_out;
    logic [IW-1:0]              wr_n;
    logic [IW-1:0]              wr_m;
    logic                       busy;
    logic                       full;
    logic                       done;

    sipo_loader #(.M(M), .N(N), .IW(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .data_out (data_out),
        .wr_n     (wr_n),
        .wr_m     (wr_m),
        .busy     (busy),
        .full     (full),
        .done     (done)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    bit chk  = 1'b0;

    // ---------------- model ----------------
    // mode: 0 idle, 1 loading, 2 full. pos is the linear row-major address.
    int          m_mode = 0;
    int          m_pos  = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_mem [N*M];

    initial for (int i = 0; i < N*M; i++) m_mem[i] = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0;
            m_pos  = 0;
            m_done = 1'b0;
            for (int i = 0; i < N*M; i++) m_mem[i] = '0;
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_mode = 1;
                m_pos  = 0;
            end else if (m_mode == 1 && in_valid) begin
                m_mem[m_pos] = in_data;
                m_pos++;
                if (m_pos == N*M) begin
                    m_pos  = 0;
                    m_mode = 2;
                    m_done = 1'b1;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk) begin
            logic [N-1:0][M-1:0][31:0] e;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < M; c++)
                    e[r][c] = m_mem[r*M + c];
            check("data_out", W'(data_out), W'(e));
            check("wr_n",     W'(wr_n),     W'(m_pos / M));
            check("wr_m",     W'(wr_m),     W'(m_pos % M));
            check("busy",     W'(busy),     W'(m_mode == 1));
            check("full",     W'(full),     W'(m_mode == 2));
            check("done",     W'(done),     W'(m_done));
            check("in_ready", W'(in_ready), W'((m_mode == 1) && !start));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic s, input logic v, input logic [31:0] d);
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt;
        int guard;
        logic [15:0] pat;

        rst = 1'b1; start = 1'b1; in_valid = 1'b1; in_data = 32'h1234;
        @(posedge clk); #1;
        chk = 1'b1;
        cyc(1'b1, 1'b1, 32'h1234);
        check("rst_data",  W'(data_out), '0);
        check("rst_ready", W'(in_ready), '0);
        check("rst_busy",  W'(busy),     '0);
        check("rst_full",  W'(full),     '0);
        check("rst_done",  W'(done),     '0);
        check("rst_pos",   W'({wr_n, wr_m}), '0);
        rst = 1'b0;

        // full load 1..6
        cyc(1'b1, 1'b0, 0);
        for (int k = 1; k <= 6; k++) begin
            cyc(1'b0, 1'b1, 32'(k));
            if (k == 3) begin
                check("wrap_m", W'(wr_m), W'(0));
                check("wrap_n", W'(wr_n), W'(1));
            end
        end
        check("load_done", W'(done), W'(1));
        check("load_full", W'(full), W'(1));
        check("load_r0", W'(data_out[0]), W'({32'd3, 32'd2, 32'd1}));
        check("load_r1", W'(data_out[1]), W'({32'd6, 32'd5, 32'd4}));
        cyc(1'b0, 1'b0, 0);
        check("done_drop", W'(done), W'(0));
        check("full_hold", W'(full), W'(1));

        // FULL ignores in_valid
        cyc(1'b0, 1'b1, 32'h55);
        cyc(1'b0, 1'b1, 32'h55);
        check("full_ign", W'(data_out), W'({32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}));
        check("full_rdy", W'(in_ready), W'(0));

        // backpressure load A0..A5
        cyc(1'b1, 1'b0, 0);
        pat = 16'b1011_0010_1101_1010;
        cnt = 0;
        guard = 0;
        while (cnt < 6 && guard < 200) begin
            logic v;
            v = pat[guard % 16];
            cyc(1'b0, v, 32'hA0 + 32'(cnt));
            if (v) cnt++;
            guard++;
        end
        check("bp_guard", W'(cnt), W'(6));
        check("bp_data", W'(data_out),
              W'({32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0}));
        check("bp_full", W'(full), W'(1));

        // restart mid-load
        cyc(1'b1, 1'b0, 0);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 32'h10 + 32'(k));
        start = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
        #1;
        check("rs_ready", W'(in_ready), W'(0));
        @(posedge clk); #1;
        cyc(1'b0, 1'b1, 32'hBEEF);
        check("rs_00", W'(data_out[0][0]), W'(32'hBEEF));
        check("rs_10", W'(data_out[1][0]), W'(32'h13));
        check("rs_11", W'(data_out[1][1]), W'(32'hA4));
        check("rs_pos", W'({wr_n, wr_m}), W'({8'd0, 8'd1}));

        // reset mid-load, then reload
        cyc(1'b0, 1'b1, 32'h77);
        rst = 1'b1;
        cyc(1'b0, 1'b1, 32'h78);
        rst = 1'b0;
        check("mrst_data", W'(data_out), '0);
        check("mrst_busy", W'(busy), W'(0));
        cyc(1'b0, 1'b1, 32'h79);
        check("idle_ign", W'(data_out), '0);
        cyc(1'b1, 1'b0, 0);
        cyc(1'b0, 1'b1, 32'h99);
        check("reload_00", W'(data_out[0][0]), W'(32'h99));
        check("reload_pos", W'({wr_n, wr_m}), W'({8'd0, 8'd1}));
        cyc(1'b0, 1'b0, 0);
        cyc(1'b0, 1'b0, 0);

        chk = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
